// File: rtl/mor1kx_store_buffer_bus.sv
// Write-posting store buffer between the LSU and the 32-bit Wishbone bridge.
// Stores are accepted into a small FIFO without wait states and drained in
// order. Loads go to the bus only once every older store has completed.
// Store bus errors are imprecise and are reported through a sticky flag.
module mor1kx_store_buffer_bus #(
  parameter int DEPTH_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_adr_i,
  input  logic [31:0] lsu_dat_i,
  input  logic [3:0]  lsu_bsel_i,
  output logic        lsu_ack_o,
  output logic        lsu_err_o,
  output logic [31:0] lsu_dat_o,
  output logic        store_err_o,
  input  logic        store_err_clr_i,
  output logic        sb_empty_o,
  output logic        sb_full_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  output logic [3:0]  bus_bsel_o,
  output logic        bus_burst_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_dat_i
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;

  localparam logic [DEPTH_WIDTH:0] PTR_ONE = {{DEPTH_WIDTH{1'b0}}, 1'b1};

  logic [1:0]             state;
  logic [DEPTH_WIDTH:0]   wr_ptr;
  logic [DEPTH_WIDTH:0]   rd_ptr;
  logic [DEPTH_WIDTH-1:0] wr_idx;
  logic [DEPTH_WIDTH-1:0] rd_idx;

  logic [31:0] adr_mem  [DEPTH];
  logic [31:0] dat_mem  [DEPTH];
  logic [3:0]  bsel_mem [DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic load_ack;
  logic load_err;

  assign wr_idx = wr_ptr[DEPTH_WIDTH-1:0];
  assign rd_idx = rd_ptr[DEPTH_WIDTH-1:0];

  // Equal pointers mean empty; equal index with differing MSB means full.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[DEPTH_WIDTH] != rd_ptr[DEPTH_WIDTH]) &&
                      (wr_idx == rd_idx);

  // A completing drain frees the head slot in the same cycle, so a store
  // arriving against a full FIFO can be taken alongside the pop.
  assign pop  = (state == DRAIN) && (bus_ack_i || bus_err_i);
  assign push = lsu_req_i && lsu_we_i && (!fifo_full || pop);

  // Error outranks ack when the bridge raises both.
  assign load_ack = (state == LOAD) && bus_ack_i && !bus_err_i;
  assign load_err = (state == LOAD) && bus_err_i;

  assign lsu_ack_o = push || load_ack;
  assign lsu_err_o = load_err;
  assign lsu_dat_o = load_ack ? bus_dat_i : 32'd0;

  // Request is decoded straight from the state register, so it never glitches.
  assign bus_req_o   = (state != IDLE);
  assign bus_burst_o = 1'b0;

  // The head entry stays counted until its bus access has finished.
  assign sb_empty_o = fifo_empty && (state != DRAIN);
  assign sb_full_o  = fifo_full;

  // Storage for posted stores; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem[wr_idx]  <= lsu_adr_i;
      dat_mem[wr_idx]  <= lsu_dat_i;
      bsel_mem[wr_idx] <= lsu_bsel_i;
    end
  end

  // FIFO pointers advance on accepted stores and on completed drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Bus sequencer: every access passes through IDLE, leaving a one-cycle gap
  // between accesses; queued stores take priority over a waiting load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bus_we_o   <= 1'b0;
      bus_adr_o  <= 32'd0;
      bus_dat_o  <= 32'd0;
      bus_bsel_o <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            bus_we_o   <= 1'b1;
            bus_adr_o  <= adr_mem[rd_idx];
            bus_dat_o  <= dat_mem[rd_idx];
            bus_bsel_o <= bsel_mem[rd_idx];
            state      <= DRAIN;
          end else if (lsu_req_i && !lsu_we_i) begin
            bus_we_o   <= 1'b0;
            bus_adr_o  <= lsu_adr_i;
            bus_bsel_o <= lsu_bsel_i;
            state      <= LOAD;
          end
        end
        DRAIN: begin
          if (bus_ack_i || bus_err_i) state <= IDLE;
        end
        LOAD: begin
          if (bus_ack_i || bus_err_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky store error; a new error beats a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_err_o <= 1'b0;
    end else if ((state == DRAIN) && bus_err_i) begin
      store_err_o <= 1'b1;
    end else if (store_err_clr_i) begin
      store_err_o <= 1'b0;
    end
  end

endmodule
